// File: rtl/vend_controller.sv
// Vending controller: collects coins, vends one of four items and pays change one unit per cycle.
// A single shared subtractor serves both the price check and the change countdown.

module vend_sub #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);
  assign {borrow_out, diff} = {1'b0, a} - {1'b0, b};
endmodule

module vend_controller #(
  parameter int N      = 4,
  parameter int PRICE0 = 3,
  parameter int PRICE1 = 5,
  parameter int PRICE2 = 7,
  parameter int PRICE3 = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         coin_valid,
  input  logic [1:0]   coin_val,
  input  logic         sel_valid,
  input  logic [1:0]   sel,
  input  logic         cancel,
  output logic [N-1:0] credit,
  output logic         dispense,
  output logic [1:0]   dispense_item,
  output logic         change_pulse,
  output logic         coin_rej,
  output logic         insufficient,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  localparam logic [N-1:0] PRICE0_C = PRICE0[N-1:0];
  localparam logic [N-1:0] PRICE1_C = PRICE1[N-1:0];
  localparam logic [N-1:0] PRICE2_C = PRICE2[N-1:0];
  localparam logic [N-1:0] PRICE3_C = PRICE3[N-1:0];
  localparam logic [N-1:0] ONE_C    = N'(1'b1);

  state_t       state_q, state_d;
  logic [N-1:0] credit_q, credit_d;
  logic         dispense_q, dispense_d;
  logic [1:0]   dispense_item_q, dispense_item_d;
  logic         change_pulse_q, change_pulse_d;
  logic         coin_rej_q, coin_rej_d;
  logic         insufficient_q, insufficient_d;
  logic         busy_q, busy_d;

  logic [N-1:0] price_sel_s, sub_b_s, diff_s;
  logic         borrow_s;
  logic [N:0]   coin_units_s, coin_sum_s;

  // Price lookup and coin decode
  always_comb begin
    price_sel_s  = PRICE0_C;
    coin_units_s = (N+1)'(1'b0);
    case (sel)
      2'd0:    price_sel_s = PRICE0_C;
      2'd1:    price_sel_s = PRICE1_C;
      2'd2:    price_sel_s = PRICE2_C;
      2'd3:    price_sel_s = PRICE3_C;
      default: price_sel_s = PRICE0_C;
    endcase
    case (coin_val)
      2'b01:   coin_units_s = (N+1)'(3'd1);
      2'b10:   coin_units_s = (N+1)'(3'd2);
      2'b11:   coin_units_s = (N+1)'(3'd5);
      default: coin_units_s = (N+1)'(1'b0);
    endcase
  end

  // During change payout the subtractor counts credit down by one instead
  assign sub_b_s    = (state_q == S_CHANGE) ? ONE_C : price_sel_s;
  assign coin_sum_s = {1'b0, credit_q} + coin_units_s;

  vend_sub #(.N(N)) u_sub (
    .a          (credit_q),
    .b          (sub_b_s),
    .diff       (diff_s),
    .borrow_out (borrow_s)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    dispense_d      = 1'b0;
    dispense_item_d = 2'b00;
    change_pulse_d  = 1'b0;
    coin_rej_d      = 1'b0;
    insufficient_d  = 1'b0;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (cancel) begin
          coin_rej_d = coin_valid;
          if (state_q == S_COLLECT) begin
            state_d = S_CHANGE;
          end else begin
            state_d = state_q;
          end
        end else if (sel_valid) begin
          coin_rej_d = coin_valid;
          if (!borrow_s) begin
            state_d         = S_VEND;
            dispense_d      = 1'b1;
            dispense_item_d = sel;
            credit_d        = diff_s;
          end else begin
            insufficient_d = 1'b1;
          end
        end else if (coin_valid) begin
          // Coins that would overflow the credit register are handed back
          if ((coin_val == 2'b00) || coin_sum_s[N]) begin
            coin_rej_d = 1'b1;
          end else begin
            credit_d = coin_sum_s[N-1:0];
            state_d  = S_COLLECT;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_VEND: begin
        coin_rej_d = coin_valid;
        if (credit_q != {N{1'b0}}) begin
          state_d = S_CHANGE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHANGE: begin
        coin_rej_d     = coin_valid;
        change_pulse_d = 1'b1;
        credit_d       = diff_s;
        if (diff_s == {N{1'b0}}) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CHANGE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      credit_q        <= {N{1'b0}};
      dispense_q      <= 1'b0;
      dispense_item_q <= 2'b00;
      change_pulse_q  <= 1'b0;
      coin_rej_q      <= 1'b0;
      insufficient_q  <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      dispense_q      <= dispense_d;
      dispense_item_q <= dispense_item_d;
      change_pulse_q  <= change_pulse_d;
      coin_rej_q      <= coin_rej_d;
      insufficient_q  <= insufficient_d;
      busy_q          <= busy_d;
    end
  end

  assign credit        = credit_q;
  assign dispense      = dispense_q;
  assign dispense_item = dispense_item_q;
  assign change_pulse  = change_pulse_q;
  assign coin_rej      = coin_rej_q;
  assign insufficient  = insufficient_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus a randomized run
// compared cycle by cycle against a credit-accounting reference model.

module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_val = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       cancel = 1'b0;
  logic [3:0] credit;
  logic       dispense;
  logic [1:0] dispense_item;
  logic       change_pulse;
  logic       coin_rej;
  logic       insufficient;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: what the customer has paid and what the machine is doing
  localparam int P_IDLE = 0, P_COLL = 1, P_VEND = 2, P_CHG = 3;
  int m_phase = P_IDLE;
  int m_credit = 0;
  int m_accepted = 0, m_forfeit = 0, out_units = 0;
  int exp_credit = 0, exp_item = 0;
  bit exp_disp, exp_pulse, exp_rej, exp_insuf, exp_busy;

  vend_controller dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_valid(sel_valid), .sel(sel), .cancel(cancel), .credit(credit),
    .dispense(dispense), .dispense_item(dispense_item), .change_pulse(change_pulse),
    .coin_rej(coin_rej), .insufficient(insufficient), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int price_of(input int i);
    int t [4] = '{3, 5, 7, 12};
    return t[i];
  endfunction

  function automatic int units_of(input int v);
    return (v == 1) ? 1 : (v == 2) ? 2 : (v == 3) ? 5 : 0;
  endfunction

  // Apply one cycle of inputs, advance the model, sample the DUT after the edge
  task automatic step(input bit cv, input int val, input bit sv, input int s,
                      input bit cn, input bit r);
    int v;
    @(negedge clk);
    coin_valid = cv; coin_val = 2'(val); sel_valid = sv; sel = 2'(s);
    cancel = cn; rst = r;
    exp_disp = 0; exp_pulse = 0; exp_rej = 0; exp_insuf = 0;
    if (r) begin
      m_forfeit += m_credit; m_credit = 0; m_phase = P_IDLE;
    end else if (m_phase == P_VEND) begin
      exp_rej = cv;
      m_phase = (m_credit > 0) ? P_CHG : P_IDLE;
    end else if (m_phase == P_CHG) begin
      exp_rej = cv; exp_pulse = 1; m_credit -= 1;
      if (m_credit == 0) m_phase = P_IDLE;
    end else if (cn) begin
      exp_rej = cv;
      if (m_phase == P_COLL) m_phase = P_CHG;
    end else if (sv) begin
      exp_rej = cv;
      if (m_credit >= price_of(s)) begin
        m_credit -= price_of(s); exp_disp = 1; exp_item = s; m_phase = P_VEND;
      end else begin
        exp_insuf = 1;
      end
    end else if (cv) begin
      v = units_of(val);
      if (v == 0 || m_credit + v > 15) begin
        exp_rej = 1;
      end else begin
        m_credit += v; m_accepted += v; m_phase = P_COLL;
      end
    end
    exp_credit = m_credit;
    exp_busy = (m_phase == P_VEND) || (m_phase == P_CHG);
    @(posedge clk);
    #1;
    if (dispense === 1'b1) out_units += price_of(int'(dispense_item));
    if (change_pulse === 1'b1) out_units += 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 1);
    n_checks++;
    if ({credit, dispense, change_pulse, coin_rej, insufficient, busy} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_state: got credit=%0d disp=%b chg=%b rej=%b ins=%b busy=%b, required all 0",
               credit, dispense, change_pulse, coin_rej, insufficient, busy);
    end
  endtask

  task automatic test_purchase_with_change();
    int credits [3] = '{5, 7, 8};
    int vals [3] = '{3, 2, 1};
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, vals[i], 0, 0, 0, 0);
      n_checks++;
      if (credit !== 4'(credits[i])) begin
        n_fail++; $display("FAIL coin_credit[%0d]: got %0d, required %0d", i, credit, credits[i]);
      end
    end
    step(0, 0, 1, 1, 0, 0);
    n_checks++;
    if (dispense !== 1'b1 || dispense_item !== 2'd1 || credit !== 4'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL vend_item1: got disp=%b item=%0d credit=%0d busy=%b, required 1/1/3/1",
               dispense, dispense_item, credit, busy);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (change_pulse !== ((i >= 1 && i <= 3) ? 1'b1 : 1'b0) ||
          credit !== ((i == 0) ? 4'd3 : (i <= 3) ? 4'(3 - i) : 4'd0)) begin
        n_fail++;
        $display("FAIL change_seq[%0d]: got pulse=%b credit=%0d", i, change_pulse, credit);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL change_done_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_insufficient();
    step(0, 0, 0, 0, 0, 1);
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 2, 0, 0);
    n_checks++;
    if (insufficient !== 1'b1 || credit !== 4'd2 || dispense !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL insufficient: got ins=%b credit=%0d disp=%b busy=%b, required 1/2/0/0",
               insufficient, credit, dispense, busy);
    end
    step(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (insufficient !== 1'b0) begin
      n_fail++; $display("FAIL insufficient_pulse: got %b, required 0", insufficient);
    end
    step(0, 0, 0, 0, 1, 0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL still_collecting: cancel gave busy=%b, required 1", busy);
    end
    idle(4);
  endtask

  task automatic test_overflow_exact();
    step(0, 0, 0, 0, 0, 1);
    step(1, 3, 0, 0, 0, 0); step(1, 3, 0, 0, 0, 0); step(1, 2, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0);
    n_checks++;
    if (coin_rej !== 1'b1 || credit !== 4'd12) begin
      n_fail++; $display("FAIL overflow_rej: got rej=%b credit=%0d, required 1/12", coin_rej, credit);
    end
    step(0, 0, 1, 3, 0, 0);
    n_checks++;
    if (dispense !== 1'b1 || dispense_item !== 2'd3 || credit !== 4'd0) begin
      n_fail++;
      $display("FAIL exact_vend: got disp=%b item=%0d credit=%0d, required 1/3/0",
               dispense, dispense_item, credit);
    end
    step(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (busy !== 1'b0 || change_pulse !== 1'b0) begin
      n_fail++; $display("FAIL exact_no_change: got busy=%b pulse=%b, required 0/0", busy, change_pulse);
    end
    step(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (change_pulse !== 1'b0) begin
      n_fail++; $display("FAIL exact_no_change2: got pulse=%b, required 0", change_pulse);
    end
  endtask

  task automatic test_cancel_priority();
    int pulses = 0, disps = 0;
    step(0, 0, 0, 0, 0, 1);
    step(1, 3, 0, 0, 0, 0); step(1, 1, 0, 0, 0, 0);
    step(1, 3, 1, 0, 1, 0);
    n_checks++;
    if (coin_rej !== 1'b1 || dispense !== 1'b0 || credit !== 4'd6 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cancel_wins: got rej=%b disp=%b credit=%0d busy=%b, required 1/0/6/1",
               coin_rej, dispense, credit, busy);
    end
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 0, 0);
      pulses += int'(change_pulse); disps += int'(dispense);
    end
    n_checks++;
    if (pulses != 6 || disps != 0 || credit !== 4'd0) begin
      n_fail++;
      $display("FAIL cancel_refund: got pulses=%0d disp=%0d credit=%0d, required 6/0/0", pulses, disps, credit);
    end
  endtask

  task automatic test_reset_mid_change();
    step(0, 0, 0, 0, 0, 1);
    step(1, 2, 0, 0, 0, 0); step(1, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (change_pulse !== 1'b1 || credit !== 4'd2) begin
      n_fail++; $display("FAIL pre_reset_change: got pulse=%b credit=%0d, required 1/2", change_pulse, credit);
    end
    step(1, 3, 1, 0, 1, 1);
    n_checks++;
    if (credit !== 4'd0 || busy !== 1'b0 || change_pulse !== 1'b0 || coin_rej !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_change: got credit=%0d busy=%b pulse=%b rej=%b, required all 0",
               credit, busy, change_pulse, coin_rej);
    end
  endtask

  task automatic test_coin_while_busy();
    step(0, 0, 0, 0, 0, 1);
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 1, 0);
      n_checks++;
      if (coin_rej !== 1'b1 || credit !== 4'(2 - i) || change_pulse !== ((i > 0) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL busy_coin[%0d]: got rej=%b credit=%0d pulse=%b", i, coin_rej, credit, change_pulse);
      end
    end
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 3) == 0, $urandom % 4, ($urandom % 7) == 0, $urandom % 4,
           ($urandom % 17) == 0, ($urandom % 90) == 0);
      n_checks++;
      if (credit !== 4'(exp_credit) || dispense !== exp_disp || change_pulse !== exp_pulse ||
          coin_rej !== exp_rej || insufficient !== exp_insuf || busy !== exp_busy ||
          (exp_disp && dispense_item !== 2'(exp_item))) begin
        n_fail++;
        $display("FAIL random[%0d]: got c=%0d d=%b i=%0d p=%b r=%b n=%b b=%b, required c=%0d d=%b i=%0d p=%b r=%b n=%b b=%b",
                 i, credit, dispense, dispense_item, change_pulse, coin_rej, insufficient, busy,
                 exp_credit, exp_disp, exp_item, exp_pulse, exp_rej, exp_insuf, exp_busy);
      end
    end
    idle(20);
  endtask

  task automatic test_conservation();
    n_checks++;
    if (m_accepted != out_units + m_forfeit + int'(credit)) begin
      n_fail++;
      $display("FAIL conservation: got out=%0d forfeit=%0d credit=%0d, required sum %0d",
               out_units, m_forfeit, credit, m_accepted);
    end
  endtask

  initial begin
    test_reset();
    test_purchase_with_change();
    test_insufficient();
    test_overflow_exact();
    test_cancel_priority();
    test_reset_mid_change();
    test_coin_while_busy();
    test_random();
    test_conservation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter N, default 4: credit/price width in units.
REQ-002 SHALL have parameters PRICE0..PRICE3, defaults 3, 5, 7, 12: item prices in units, each < 2^N.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port coin_valid  input  1  coin inserted this cycle.
REQ-006 SHALL have port coin_val  input  2  01=1 unit, 10=2 units, 11=5 units, 00=invalid.
REQ-007 SHALL have port sel_valid  input  1  item request this cycle.
REQ-008 SHALL have port sel  input  2  item index 0..3.
REQ-009 SHALL have port cancel  input  1  refund request.
REQ-010 SHALL have port credit  output  N  current credit, registered.
REQ-011 SHALL have port dispense  output  1  one-cycle vend pulse.
REQ-012 SHALL have port dispense_item  output  2  item index, valid while dispense=1.
REQ-013 SHALL have port change_pulse  output  1  one unit returned this cycle.
REQ-014 SHALL have port coin_rej  output  1  one-cycle pulse: coin refused.
REQ-015 SHALL have port insufficient  output  1  one-cycle pulse: request refused for low credit.
REQ-016 SHALL have port busy  output  1  high in VEND and CHANGE.

Function
REQ-017 SHALL implement states IDLE, COLLECT, VEND, CHANGE; all outputs registered.
REQ-018 SHALL instantiate one N-bit subtractor (DIFF, BORROW_OUT) shared: A=credit; B=selected price in IDLE/COLLECT, B=1 in CHANGE.
REQ-019 IDLE/COLLECT, coin_valid with coin_val!=00 and no sel_valid/cancel: credit<=credit+value next cycle, state<=COLLECT; if sum >= 2^N then credit unchanged, coin_rej=1 next cycle.
REQ-020 coin_val=00 with coin_valid SHALL pulse coin_rej, credit unchanged.
REQ-021 COLLECT, sel_valid, no cancel: BORROW_OUT=0 -> next cycle state=VEND, dispense=1, dispense_item=sel, credit<=DIFF.
REQ-022 COLLECT, sel_valid, BORROW_OUT=1 -> next cycle insufficient=1, credit unchanged, stay COLLECT.
REQ-023 IDLE, sel_valid -> insufficient=1 next cycle unless price is 0 (then vend per REQ-021).
REQ-024 VEND lasts exactly one cycle; then CHANGE if credit!=0, else IDLE.
REQ-025 CHANGE: each cycle change_pulse=1 and credit<=DIFF (credit-1); the cycle credit reaches 0, state<=IDLE, change_pulse=0 thereafter.
REQ-026 COLLECT, cancel -> CHANGE next cycle (full refund); cancel in IDLE is a no-op.
REQ-027 Priority same cycle: cancel > sel_valid > coin_valid; a lower-priority coin_valid SHALL pulse coin_rej.
REQ-028 While busy=1 coin_valid SHALL pulse coin_rej; sel_valid and cancel SHALL be ignored.
REQ-029 Total units out (price + change_pulse count) SHALL equal total units accepted.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, credit=0, all pulse outputs 0, busy=0, from any state incl. mid-CHANGE; pending change is forfeited.
REQ-031 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-032 Coins 5,2,1 then sel=1 (price 5) -> credit 5,7,8; dispense=1 item 1 credit 3; 3 change_pulse cycles; IDLE credit 0.
REQ-033 Credit 2, sel=2 (price 7) -> insufficient=1 one cycle, credit stays 2, state COLLECT.
REQ-034 Credit 12, coin 5 -> coin_rej=1, credit stays 12; sel=3 -> dispense, credit 0, straight to IDLE, no change_pulse.
REQ-035 Credit 6, cancel+sel+coin same cycle -> cancel wins, coin_rej=1, 6 change_pulses, no dispense.
REQ-036 rst asserted after 2 of 4 change pulses -> next cycle credit 0, busy 0, change_pulse 0.
REQ-037 coin during VEND/CHANGE -> coin_rej=1, credit sequence unaffected.
